// File: rtl/zx_io_pkg.sv
// Shared constants and types for the Spectrum I/O controller:
// port addresses, port bit positions and the INT sequencer states.
package zx_io_pkg;

    localparam logic [15:0] PORT_7FFD = 16'h7FFD;
    localparam logic [15:0] PORT_FFFD = 16'hFFFD;
    localparam logic [15:0] PORT_BFFD = 16'hBFFD;

    // Port FE data bits
    localparam int unsigned FE_BORDER_LSB = 0;
    localparam int unsigned FE_TAPE       = 3;
    localparam int unsigned FE_SPK        = 4;

    // Port 7FFD data bits
    localparam int unsigned P7_BANK_LSB = 0;
    localparam int unsigned P7_SCREEN   = 3;
    localparam int unsigned P7_ROM      = 4;
    localparam int unsigned P7_LOCK     = 5;

    typedef enum logic {IDLE, ACTIVE} int_state_e;

endpackage

// File: rtl/zx_io_ctrl_if.sv
// CPU I/O bus as seen by the controller: address, data and the
// asynchronous active-low strobes.
interface zx_io_ctrl_if;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_niorq;
    logic        cpu_nwr;
    logic        cpu_nm1;

    modport master (output cpu_a, cpu_d, cpu_niorq, cpu_nwr, cpu_nm1);
    modport slave  (input  cpu_a, cpu_d, cpu_niorq, cpu_nwr, cpu_nm1);
endinterface

// File: rtl/zx_sync_edge.sv
// Reset-to-high synchroniser for one asynchronous input, with
// single-cycle fall/rise pulses derived from the synchronised level.
module zx_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock_25,
    input  logic RESET_N,
    input  logic d,
    output logic q,
    output logic fall,
    output logic rise
);

    logic [STAGES-1:0] sr;
    logic              q_d;

    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            sr  <= '1;
            q_d <= 1'b1;
        end else begin
            sr  <= {sr[STAGES-2:0], d};
            q_d <= sr[STAGES-1];
        end
    end

    assign q    = sr[STAGES-1];
    assign fall = q_d & ~q;
    assign rise = ~q_d & q;

endmodule

// File: rtl/zx_io_ctrl.sv
// CPU I/O write decode (7FFD paging, FE ULA port) and frame INT pulse generator.
// Define ZX_IO_CTRL_AY_EN to add the AY register-select/data write ports.
module zx_io_ctrl
    import zx_io_pkg::*;
#(
    parameter int unsigned INT_WIDTH   = 229,
    parameter bit          FULL_DECODE = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clock_25,
    input  logic               RESET_N,
    zx_io_ctrl_if.slave        cpu,
    input  logic               vblank_n,
    output logic               int_n,
    output logic [7:0]         port7ffd,
    output logic               rom_sel,
    output logic [2:0]         top_bank,
    output logic               screen_sel,
    output logic               locked,
    output logic [2:0]         border,
    output logic               speaker,
    output logic               tape_out
`ifdef ZX_IO_CTRL_AY_EN
    ,
    output logic [3:0]         ay_reg,
    output logic [7:0]         ay_wdata,
    output logic [0:0]         ay_we
`endif
);

    localparam int unsigned CNT_W = (INT_WIDTH > 2) ? $clog2(INT_WIDTH) : 1;

    logic niorq_s, nwr_s, nm1_s, vblank_s;
    logic vb_fall;
    logic [6:0] unused_edges;

    zx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_iorq (
        .clock_25(clock_25), .RESET_N(RESET_N), .d(cpu.cpu_niorq),
        .q(niorq_s), .fall(unused_edges[0]), .rise(unused_edges[1]));
    zx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clock_25(clock_25), .RESET_N(RESET_N), .d(cpu.cpu_nwr),
        .q(nwr_s), .fall(unused_edges[2]), .rise(unused_edges[3]));
    zx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_m1 (
        .clock_25(clock_25), .RESET_N(RESET_N), .d(cpu.cpu_nm1),
        .q(nm1_s), .fall(unused_edges[4]), .rise(unused_edges[5]));
    zx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vbl (
        .clock_25(clock_25), .RESET_N(RESET_N), .d(vblank_n),
        .q(vblank_s), .fall(vb_fall), .rise(unused_edges[6]));

    // M1 high excludes interrupt-acknowledge cycles from write decode
    logic io_wr_s, io_wr_d, wr_pulse, int_ack;
    assign io_wr_s  = ~niorq_s & ~nwr_s & nm1_s;
    assign wr_pulse = io_wr_s & ~io_wr_d;
    assign int_ack  = ~niorq_s & ~nm1_s;

    logic hit_7ffd, hit_fe;
    assign hit_7ffd = FULL_DECODE ? (cpu.cpu_a == PORT_7FFD)
                                  : (~cpu.cpu_a[15] & ~cpu.cpu_a[1]);
    assign hit_fe   = ~cpu.cpu_a[0];

    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            io_wr_d  <= 1'b0;
            port7ffd <= '0;
            border   <= '0;
            speaker  <= 1'b0;
            tape_out <= 1'b0;
        end else begin
            io_wr_d <= io_wr_s;
            if (wr_pulse) begin
                if (hit_7ffd && !port7ffd[P7_LOCK])
                    port7ffd <= cpu.cpu_d;
                if (hit_fe) begin
                    border   <= cpu.cpu_d[FE_BORDER_LSB +: 3];
                    tape_out <= cpu.cpu_d[FE_TAPE];
                    speaker  <= cpu.cpu_d[FE_SPK] ^ cpu.cpu_d[FE_TAPE];
                end
            end
        end
    end

`ifdef ZX_IO_CTRL_AY_EN
    logic hit_fffd, hit_bffd;
    assign hit_fffd = (cpu.cpu_a[15:14] == PORT_FFFD[15:14]) & ~cpu.cpu_a[1];
    assign hit_bffd = (cpu.cpu_a[15:14] == PORT_BFFD[15:14]) & ~cpu.cpu_a[1];

    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            ay_reg   <= '0;
            ay_wdata <= '0;
            ay_we    <= '0;
        end else begin
            ay_we <= '0;
            if (wr_pulse && hit_fffd)
                ay_reg <= cpu.cpu_d[3:0];
            if (wr_pulse && hit_bffd) begin
                ay_wdata <= cpu.cpu_d;
                ay_we    <= 1'b1;
            end
        end
    end
`endif

    assign rom_sel    = port7ffd[P7_ROM] | port7ffd[P7_LOCK];
    assign locked     = port7ffd[P7_LOCK];
    assign screen_sel = port7ffd[P7_SCREEN];
    assign top_bank   = port7ffd[P7_LOCK] ? 3'b000 : port7ffd[P7_BANK_LSB +: 3];

    // Vblank edges during ACTIVE are dropped, not queued
    int_state_e       st;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock_25) begin
        if (!RESET_N) begin
            st    <= IDLE;
            cnt   <= '0;
            int_n <= 1'b1;
        end else begin
            case (st)
                IDLE: if (vb_fall) begin
                    st    <= ACTIVE;
                    cnt   <= CNT_W'(INT_WIDTH - 1);
                    int_n <= 1'b0;
                end
                ACTIVE: if (int_ack || cnt == '0) begin
                    st    <= IDLE;
                    int_n <= 1'b1;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
                default: begin
                    st    <= IDLE;
                    int_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zx_io_ctrl.sv
// Scoreboard bench for zx_io_ctrl: one full-decode and one partial-decode
// instance share the CPU bus; expected port state is queued per write.
module tb_zx_io_ctrl;

    logic clock_25 = 1'b0;
    logic RESET_N  = 1'b0;
    logic vblank_n = 1'b1;
    always #20 clock_25 = ~clock_25;

    zx_io_ctrl_if bus();

    logic       int_f, rom_f, scr_f, lock_f, spk_f, tape_f;
    logic [7:0] p7_f;
    logic [2:0] top_f, border_f;
    logic       int_p, rom_p, scr_p, lock_p, spk_p, tape_p;
    logic [7:0] p7_p;
    logic [2:0] top_p, border_p;
`ifdef ZX_IO_CTRL_AY_EN
    logic [3:0] ayr_f, ayr_p;
    logic [7:0] ayd_f, ayd_p;
    logic [0:0] aywe_f, aywe_p;
    int         ay_cnt = 0;
    logic [7:0] ay_seen = '0;
    always @(posedge clock_25) if (aywe_f[0]) begin ay_cnt++; ay_seen = ayd_f; end
`endif

    zx_io_ctrl #(.INT_WIDTH(229), .FULL_DECODE(1'b1), .SYNC_STAGES(2)) dut_f (
        .clock_25(clock_25), .RESET_N(RESET_N), .cpu(bus.slave), .vblank_n(vblank_n),
        .int_n(int_f), .port7ffd(p7_f), .rom_sel(rom_f), .top_bank(top_f),
        .screen_sel(scr_f), .locked(lock_f), .border(border_f), .speaker(spk_f),
        .tape_out(tape_f)
`ifdef ZX_IO_CTRL_AY_EN
        , .ay_reg(ayr_f), .ay_wdata(ayd_f), .ay_we(aywe_f)
`endif
    );

    zx_io_ctrl #(.INT_WIDTH(229), .FULL_DECODE(1'b0), .SYNC_STAGES(2)) dut_p (
        .clock_25(clock_25), .RESET_N(RESET_N), .cpu(bus.slave), .vblank_n(vblank_n),
        .int_n(int_p), .port7ffd(p7_p), .rom_sel(rom_p), .top_bank(top_p),
        .screen_sel(scr_p), .locked(lock_p), .border(border_p), .speaker(spk_p),
        .tape_out(tape_p)
`ifdef ZX_IO_CTRL_AY_EN
        , .ay_reg(ayr_p), .ay_wdata(ayd_p), .ay_we(aywe_p)
`endif
    );

    logic [29:0] obs;
    assign obs = {p7_f, rom_f, top_f, scr_f, lock_f, border_f, spk_f, tape_f, p7_p, top_p};

    typedef struct packed {
        logic [7:0] p7f;
        logic [7:0] p7p;
        logic [2:0] border;
        logic       spk;
        logic       tape;
    } mstate_t;

    mstate_t     m = '0;
    logic [29:0] sb[$];
    int          int_q[$];
    int          total = 0;
    int          bad = 0;

    function automatic logic [29:0] pack_exp(input mstate_t s);
        return {s.p7f, s.p7f[4] | s.p7f[5], s.p7f[5] ? 3'b000 : s.p7f[2:0], s.p7f[3], s.p7f[5],
                s.border, s.spk, s.tape, s.p7p, s.p7p[5] ? 3'b000 : s.p7p[2:0]};
    endfunction

    function automatic mstate_t apply_write(input mstate_t s, input logic [15:0] a,
                                            input logic [7:0] d);
        mstate_t r = s;
        if (a == 16'h7FFD && !s.p7f[5]) r.p7f = d;
        if (!a[15] && !a[1] && !s.p7p[5]) r.p7p = d;
        if (!a[0]) begin
            r.border = d[2:0];
            r.tape   = d[3];
            r.spk    = d[4] ^ d[3];
        end
        return r;
    endfunction

    // Starts an OUT, queues the expected state, returns one clock before the update is due
    task automatic drive_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clock_25); #5;
        bus.cpu_a = a; bus.cpu_d = d;
        bus.cpu_nm1 = 1'b1; bus.cpu_niorq = 1'b0; bus.cpu_nwr = 1'b0;
        m = apply_write(m, a, d);
        sb.push_back(pack_exp(m));
        repeat (2) @(posedge clock_25);
        #1;
    endtask

    task automatic bus_idle();
        bus.cpu_niorq = 1'b1; bus.cpu_nwr = 1'b1; bus.cpu_nm1 = 1'b1;
        repeat (4) @(posedge clock_25);
        #1;
    endtask

    task automatic test_reset();
        logic [29:0] want;
        repeat (3) @(posedge clock_25);
        #1;
        want = pack_exp(m);
        total++; if (obs !== want) begin bad++; $display("FAIL reset_regs: got %h want %h", obs, want); end
        total++; if ({int_f, int_p} !== 2'b11) begin bad++; $display("FAIL reset_int: got %b want 11", {int_f, int_p}); end
        RESET_N = 1'b1;
        repeat (2) @(posedge clock_25);
        #1;
    endtask

    task automatic test_7ffd();
        logic [29:0] prev, want;
        prev = pack_exp(m);
        drive_write(16'h7FFD, 8'h17);
        total++; if (obs !== prev) begin bad++; $display("FAIL 7ffd_early: got %h want %h", obs, prev); end
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL 7ffd_17: got %h want %h", obs, want); end
        bus_idle();
    endtask

    task automatic test_lock();
        logic [29:0] want;
        drive_write(16'h7FFD, 8'h20);
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL lock_set: got %h want %h", obs, want); end
        bus_idle();
        drive_write(16'h7FFD, 8'h07);
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL lock_hold: got %h want %h", obs, want); end
        bus_idle();
        #4; RESET_N = 1'b0;
        @(posedge clock_25); #1;
        RESET_N = 1'b1;
        m = '0;
        want = pack_exp(m);
        total++; if (obs !== want) begin bad++; $display("FAIL lock_reset: got %h want %h", obs, want); end
    endtask

    task automatic test_fe();
        logic [29:0] prev, want;
        prev = pack_exp(m);
        drive_write(16'h00FE, 8'h1D);
        total++; if (obs !== prev) begin bad++; $display("FAIL fe_early: got %h want %h", obs, prev); end
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL fe_1d: got %h want %h", obs, want); end
        bus_idle();
        drive_write(16'h00FE, 8'h10);
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL fe_10: got %h want %h", obs, want); end
        bus_idle();
    endtask

    task automatic test_hold();
        logic [29:0] want;
        drive_write(16'h00FE, 8'h07);
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL hold_first: got %h want %h", obs, want); end
        // A repeated pulse while WR stays low would pick up this new data
        bus.cpu_d = 8'h02;
        repeat (47) @(posedge clock_25);
        #1;
        total++; if (obs !== want) begin bad++; $display("FAIL hold_single: got %h want %h", obs, want); end
        bus_idle();
        total++; if (obs !== want) begin bad++; $display("FAIL hold_release: got %h want %h", obs, want); end
    endtask

    task automatic test_both_ports();
        logic [29:0] want;
        drive_write(16'h7FFC, 8'h13);
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL both_7ffc: got %h want %h", obs, want); end
        bus_idle();
        drive_write(16'h3FFD, 8'h03);
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL partial_3ffd: got %h want %h", obs, want); end
        total++; if (top_p !== 3'd3) begin bad++; $display("FAIL partial_top: got %0d want 3", top_p); end
        bus_idle();
    endtask

    task automatic test_ay();
        logic [29:0] want;
`ifdef ZX_IO_CTRL_AY_EN
        int c0;
        c0 = ay_cnt;
`endif
        drive_write(16'hFFFD, 8'h07);
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL ay_fffd_ports: got %h want %h", obs, want); end
        bus_idle();
        drive_write(16'hBFFD, 8'h38);
        @(posedge clock_25); #1;
        want = sb.pop_front();
        total++; if (obs !== want) begin bad++; $display("FAIL ay_bffd_ports: got %h want %h", obs, want); end
        bus_idle();
`ifdef ZX_IO_CTRL_AY_EN
        total++; if (ayr_f !== 4'h7) begin bad++; $display("FAIL ay_reg: got %h want 7", ayr_f); end
        total++; if (ay_cnt - c0 !== 1) begin bad++; $display("FAIL ay_we_count: got %0d want 1", ay_cnt - c0); end
        total++; if (ay_seen !== 8'h38) begin bad++; $display("FAIL ay_wdata: got %h want 38", ay_seen); end
`endif
    endtask

    task automatic test_int();
        int lo_f, lo_p, want;
        @(posedge clock_25); #5;
        vblank_n = 1'b0;
        int_q.push_back(229);
        repeat (2) @(posedge clock_25);
        #1;
        total++; if ({int_f, int_p} !== 2'b11) begin bad++; $display("FAIL int_early: got %b want 11", {int_f, int_p}); end
        @(posedge clock_25); #1;
        total++; if ({int_f, int_p} !== 2'b00) begin bad++; $display("FAIL int_start: got %b want 00", {int_f, int_p}); end
        lo_f = 0; lo_p = 0;
        for (int c = 0; c < 400; c++) begin
            if (!int_f) lo_f++;
            if (!int_p) lo_p++;
            if (c == 50) begin #4; vblank_n = 1'b1; end
            if (c == 100) begin #4; vblank_n = 1'b0; end
            @(posedge clock_25); #1;
        end
        want = int_q.pop_front();
        total++; if (lo_f !== want) begin bad++; $display("FAIL int_width_f: got %0d want %0d", lo_f, want); end
        total++; if (lo_p !== want) begin bad++; $display("FAIL int_width_p: got %0d want %0d", lo_p, want); end
        vblank_n = 1'b1;
        repeat (5) @(posedge clock_25);
        #1;
    endtask

    task automatic test_ack();
        int lo_f, lo_p, want, k;
        logic [29:0] cur;
        @(posedge clock_25); #5;
        vblank_n = 1'b0;
        int_q.push_back(43);
        k = 0;
        while (int_f && k < 10) begin @(posedge clock_25); #1; k++; end
        total++; if (int_f !== 1'b0) begin bad++; $display("FAIL ack_int_start: got %b want 0", int_f); end
        lo_f = 1; lo_p = int_p ? 0 : 1;
        for (int i = 1; i < 300; i++) begin
            @(posedge clock_25); #1;
            if (!int_f) lo_f++;
            if (!int_p) lo_p++;
            if (i == 40) begin
                #4;
                bus.cpu_a = 16'h7FFC; bus.cpu_d = 8'hFF;
                bus.cpu_nm1 = 1'b0; bus.cpu_niorq = 1'b0;
            end
            if (i == 60) bus_idle();
        end
        want = int_q.pop_front();
        total++; if (lo_f !== want) begin bad++; $display("FAIL ack_width_f: got %0d want %0d", lo_f, want); end
        total++; if (lo_p !== want) begin bad++; $display("FAIL ack_width_p: got %0d want %0d", lo_p, want); end
        cur = pack_exp(m);
        total++; if (obs !== cur) begin bad++; $display("FAIL ack_no_write: got %h want %h", obs, cur); end
        vblank_n = 1'b1;
        repeat (5) @(posedge clock_25);
        #1;
    endtask

    task automatic test_int_reset();
        logic [29:0] want;
        int k;
        @(posedge clock_25); #5;
        vblank_n = 1'b0;
        k = 0;
        while (int_f && k < 10) begin @(posedge clock_25); #1; k++; end
        total++; if (int_f !== 1'b0) begin bad++; $display("FAIL rst_int_start: got %b want 0", int_f); end
        repeat (10) @(posedge clock_25);
        #4;
        RESET_N = 1'b0; vblank_n = 1'b1;
        @(posedge clock_25); #1;
        RESET_N = 1'b1;
        m = '0;
        want = pack_exp(m);
        total++; if ({int_f, int_p} !== 2'b11) begin bad++; $display("FAIL rst_int_release: got %b want 11", {int_f, int_p}); end
        total++; if (obs !== want) begin bad++; $display("FAIL rst_regs: got %h want %h", obs, want); end
        repeat (8) @(posedge clock_25);
        #1;
        total++; if ({int_f, int_p} !== 2'b11) begin bad++; $display("FAIL rst_int_stays: got %b want 11", {int_f, int_p}); end
    endtask

    initial begin
        bus.cpu_a = '0; bus.cpu_d = '0;
        bus.cpu_niorq = 1'b1; bus.cpu_nwr = 1'b1; bus.cpu_nm1 = 1'b1;
        test_reset();
        test_7ffd();
        test_lock();
        test_fe();
        test_hold();
        test_both_ports();
        test_ay();
        test_int();
        test_ack();
        test_int_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/zx_io_ctrl.md
Name: zx_io_ctrl

Overview:
Clock_25-domain controller that sequences the CPU-to-resource side of the Spectrum core. It decodes CPU I/O writes and owns the 128K paging register (port 7FFD) with its lock bit, the ULA port FE state (border, speaker, tape out) and the frame interrupt. CPU bus strobes are asynchronous to clock_25, so the block synchronises them, turns each I/O write into exactly one update, and generates a fixed-width INT pulse from video vblank instead of a level. It sits between z80_top_direct_n, the memory mapper, video and the audio output.

Parameters:
INT_WIDTH, 229, INT low time in clock_25 cycles (32 T-states at 3.5 MHz)
FULL_DECODE, 1, 1 = 7FFD decoded on all 16 address bits; 0 = partial decode A15=0 and A1=0
SYNC_STAGES, 2, synchroniser depth on cpu_niorq, cpu_nwr, cpu_nm1, vblank_n (legal range 2..3)

Ports:
clock_25  in  1  system clock, 25 MHz
RESET_N  in  1  synchronous, active-low reset
cpu_a  in  16  CPU address bus
cpu_d  in  8  CPU data bus, driven by the CPU during writes
cpu_niorq  in  1  CPU IORQ, active-low, asynchronous
cpu_nwr  in  1  CPU WR, active-low, asynchronous
cpu_nm1  in  1  CPU M1, active-low, asynchronous
vblank_n  in  1  video vertical blank, active-low, asynchronous
int_n  out  1  CPU INT, active-low
port7ffd  out  8  current paging register
rom_sel  out  1  ROM half select: port7ffd[4] | port7ffd[5]
top_bank  out  3  bank mapped at C000, forced to 000 while locked
screen_sel  out  1  video bank select: 0 = bank 5, 1 = bank 7 (port7ffd[3])
locked  out  1  port7ffd[5]
border  out  3  border colour
speaker  out  1  port FE D4 ^ D3
tape_out  out  1  port FE D3

Behaviour:
- Reset (RESET_N=0 at a clock edge): port7ffd=0, border=0, speaker=0, tape_out=0, int_n=1, INT FSM to IDLE, synchronisers to 1, edge registers to idle. All outputs are registered.
- Write detect: io_wr_s = ~niorq_s & ~nwr_s & nm1_s. Fire one wr_pulse on the 0->1 edge of io_wr_s. cpu_a and cpu_d are sampled in that same cycle; both are stable because WR is held for at least 1 T-state. Latency from the WR fall to the register update is SYNC_STAGES+1 clocks (3 at default).
- Holding WR low fires no further pulse. A new pulse requires io_wr_s to deassert first.
- 7FFD match: FULL_DECODE ? cpu_a==7FFD : (~a[15] & ~a[1]). Load port7ffd=cpu_d only when locked=0. While locked, writes are ignored until reset.
- FE match: a[0]=0. Load border=d[2:0], tape_out=d[3], speaker=d[4]^d[3].
- FFFD and BFFD have no effect unless the macro is defined.
- If one write matches both 7FFD (partial decode) and FE, both registers update in the same cycle.
- Derived outputs follow port7ffd combinationally from the register: top_bank = locked ? 000 : port7ffd[2:0].
- INT FSM:
  - IDLE: on the falling edge of vblank_s -> ACTIVE, cnt=INT_WIDTH-1, int_n=0.
  - ACTIVE: cnt decrements each clock. At cnt==0 -> IDLE, int_n=1.
  - Acknowledge: if ~niorq_s & ~nm1_s -> IDLE, int_n=1 on the next clock.
  - A vblank edge that arrives during ACTIVE is ignored; no restart, no queueing.
  - Reset during ACTIVE releases INT immediately.

Optional Feature:
ZX_IO_CTRL_AY_EN
- Defined: adds outputs ay_reg[3:0], ay_wdata[7:0], ay_we[0:0].
  - A write to FFFD (a[15:14]=11, a[1]=0) latches ay_reg=d[3:0].
  - A write to BFFD (a[15:14]=10, a[1]=0) drives ay_wdata=d and a 1-clock ay_we pulse in the same cycle as wr_pulse+1.
  - Reset clears all three.
- Undefined: these ports are absent and FFFD/BFFD writes are ignored.

Decomposition:
- Package zx_io_pkg: port address constants (PORT_7FFD, PORT_FFFD, PORT_BFFD), FE bit indices, 7FFD bit indices (BANK, SCREEN, ROM, LOCK), INT FSM state enum {IDLE, ACTIVE}.
- One sub-module, zx_sync_edge: parameterised synchroniser with fall/rise pulse outputs. It is instantiated per async input.

Test Plan:
- OUT (7FFD),0x17 -> after 3 clocks port7ffd=17, top_bank=7, rom_sel=1, screen_sel=0, locked=0.
- OUT (7FFD),0x20, then OUT (7FFD),0x07 -> port7ffd stays 20, top_bank=0, rom_sel=1. RESET_N low for 1 clock -> port7ffd=00.
- OUT (FE),0x1D -> border=5, tape_out=1, speaker=0. OUT (FE),0x10 -> speaker=1, tape_out=0. Holding WR for 50 clocks -> exactly one update.
- vblank_n falls with no ack -> int_n low for exactly 229 clocks. A second vblank edge at clock 100 produces no extension.
- vblank_n falls, then nM1=0 and nIORQ=0 at clock 40 -> int_n returns high at clock 40+3. The IORQ+M1 cycle causes no 7FFD or FE write.
- FULL_DECODE=0: write to 0x3FFD with d=0x03 -> top_bank=3. With FULL_DECODE=1 the same write leaves port7ffd unchanged. Under ZX_IO_CTRL_AY_EN, FFFD=0x07 then BFFD=0x38 -> ay_reg=7, one ay_we pulse with ay_wdata=38.
